wb_writeback: RTL and testbench
===============================

WB_WRITEBACK -- requirements
Module: wb_writeback

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning the register-file data width.
REQ-002 The block SHALL have parameter NB_REG, default 5, meaning the register-address width.
REQ-003 The block SHALL have parameter NB_LOAD, default 3, meaning the load-type code width.
REQ-004 The block SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port i_reset  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port i_valid  input  1  MEM-stage result valid this cycle.
REQ-007 The block SHALL have port i_reg_write  input  1  result writes a register.
REQ-008 The block SHALL have port i_mem_to_reg  input  1  1 = take load data, 0 = take ALU result.
REQ-009 The block SHALL have port i_load_type  input  NB_LOAD  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
REQ-010 The block SHALL have port i_byte_offset  input  2  address bits [1:0] of the load.
REQ-011 The block SHALL have port i_alu_result  input  NB_DATA  ALU result.
REQ-012 The block SHALL have port i_mem_data  input  NB_DATA  raw aligned memory word.
REQ-013 The block SHALL have port i_dest  input  NB_REG  destination register.
REQ-014 The block SHALL have port i_issue_valid  input  1  ID issues an instruction this cycle.
REQ-015 The block SHALL have port i_issue_reg_write  input  1  issued instruction writes a register.
REQ-016 The block SHALL have port i_issue_dest  input  NB_REG  destination of the issued instruction.
REQ-017 The block SHALL have ports i_rs and i_rt  input  NB_REG each  ID source addresses to check.
REQ-018 The block SHALL have port i_flush  input  1  pipeline flush, clears scoreboard.
REQ-019 The block SHALL have ports o_data_input  output  NB_DATA, o_address_data  output  NB_REG, and o_write  output  1, forming the register-file write port.
REQ-020 The block SHALL have ports o_busy_rs and o_busy_rt  output  1 each  source has a pending write.
REQ-021 The block SHALL have port o_sb_error  output  1  sticky scoreboard overflow/underflow flag.

Function
REQ-022 Retire SHALL be defined as i_valid & i_reg_write & (i_dest != 0).
REQ-023 On each edge, o_write SHALL take the retire value; latency from MEM input to write port SHALL be 1 cycle.
REQ-024 On retire, o_address_data SHALL load i_dest and o_data_input SHALL load the selected data; otherwise both SHALL hold their values.
REQ-025 When i_mem_to_reg=0, selected data SHALL be i_alu_result unmodified.
REQ-026 LW: data SHALL be i_mem_data; byte lanes are little-endian, offset 0 = bits [7:0].
REQ-027 LB/LBU: byte at i_byte_offset SHALL be sign-/zero-extended to NB_DATA.
REQ-028 LH/LHU: halfword at i_byte_offset[1] SHALL be sign-/zero-extended; i_byte_offset[0] is ignored.
REQ-029 Load codes 101-111 SHALL behave as LW.
REQ-030 The scoreboard SHALL hold one 2-bit pending counter per register 1..31; register 0 is never tracked.
REQ-031 Issue (i_issue_valid & i_issue_reg_write & dest!=0) SHALL increment the counter; retire SHALL decrement it.
REQ-032 Simultaneous issue and retire to the same register SHALL leave that counter unchanged.
REQ-033 Increment at 3 SHALL saturate and set o_sb_error; decrement at 0 SHALL hold 0 and set o_sb_error.
REQ-034 i_flush SHALL zero all counters on the next edge, overriding simultaneous issue/retire; o_write SHALL still follow REQ-023.
REQ-035 o_busy_rs/o_busy_rt SHALL be combinational: counter(addr) != 0, forced 0 for address 0.

Reset
REQ-036 i_reset SHALL asynchronously clear o_write, o_data_input, o_address_data, all counters and o_sb_error to 0; o_sb_error clears only on reset.

Structure
REQ-037 Load-type codes and NB_* defaults SHALL live in the shared MIPS package.
REQ-038 Load extraction/extension SHALL be a combinational sub-module wb_load_align; scoreboard and write-port registers SHALL stay in wb_writeback.

Verification
REQ-039 LB, offset 2, mem 0x0080_FF11, dest 5 -> next cycle o_write=1, addr 5, data 0xFFFF_FF80.
REQ-040 LHU, offset 2, mem 0x8001_7FFF -> data 0x0000_8001; LH same -> 0xFFFF_8001.
REQ-041 ALU result 0x1234_5678, dest 0, reg_write=1 -> o_write stays 0, no counter change.
REQ-042 Issue dest 7 twice, retire 7 once -> o_busy_rs=1 for i_rs=7; second retire -> o_busy_rs=0.
REQ-043 Issue dest 3 four times -> counter 3, o_sb_error=1 sticky; i_flush -> busy 0, error remains 1.
REQ-044 i_reset asserted mid-cycle during retire -> all outputs 0 immediately, before next edge.

Source files
------------

// File: rtl/wb_writeback_pkg.sv
// Shared MIPS pipeline definitions: data/register widths and load-type codes.
// Imported by the writeback stage and its load alignment helper.
package wb_writeback_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_REG_DEF  = 5;
   localparam int NB_LOAD_DEF = 3;

   typedef enum logic [2:0] {
      LD_LW  = 3'b000,
      LD_LB  = 3'b001,
      LD_LBU = 3'b010,
      LD_LH  = 3'b011,
      LD_LHU = 3'b100
   } load_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data extraction: picks the addressed byte/halfword
// of a little-endian memory word and sign- or zero-extends it.
module wb_load_align
   import wb_writeback_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_LOAD = NB_LOAD_DEF
) (
   input  logic               i_mem_to_reg,
   input  logic [NB_LOAD-1:0] i_load_type,
   input  logic [1:0]         i_byte_offset,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic [NB_DATA-1:0] i_mem_data,
   output logic [NB_DATA-1:0] o_data
);

   logic [NB_DATA-1:0] b_sh;
   logic [NB_DATA-1:0] h_sh;
   logic [7:0]         b;
   logic [15:0]        h;
   logic               is_lb;
   logic               is_lbu;
   logic               is_lh;
   logic               is_lhu;

   assign b_sh = i_mem_data >> {i_byte_offset, 3'b000};
   assign h_sh = i_mem_data >> {i_byte_offset[1], 4'b0000};
   assign b    = b_sh[7:0];
   assign h    = h_sh[15:0];

   assign is_lb  = i_load_type == NB_LOAD'(LD_LB);
   assign is_lbu = i_load_type == NB_LOAD'(LD_LBU);
   assign is_lh  = i_load_type == NB_LOAD'(LD_LH);
   assign is_lhu = i_load_type == NB_LOAD'(LD_LHU);

   // Unlisted codes fall through to a full-word load.
   always_comb begin
      o_data = i_mem_data;
      if (!i_mem_to_reg) begin
         o_data = i_alu_result;
      end else begin
         unique case (1'b1)
            is_lb:   o_data = {{(NB_DATA-8){b[7]}}, b};
            is_lbu:  o_data = {{(NB_DATA-8){1'b0}}, b};
            is_lh:   o_data = {{(NB_DATA-16){h[15]}}, h};
            is_lhu:  o_data = {{(NB_DATA-16){1'b0}}, h};
            default: o_data = i_mem_data;
         endcase
      end
   end

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: registered register-file write port plus a per-register
// pending-write scoreboard that ID uses to detect outstanding results.
module wb_writeback
   import wb_writeback_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_REG  = NB_REG_DEF,
   parameter int NB_LOAD = NB_LOAD_DEF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic               i_reg_write,
   input  logic               i_mem_to_reg,
   input  logic [NB_LOAD-1:0] i_load_type,
   input  logic [1:0]         i_byte_offset,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic [NB_DATA-1:0] i_mem_data,
   input  logic [NB_REG-1:0]  i_dest,
   input  logic               i_issue_valid,
   input  logic               i_issue_reg_write,
   input  logic [NB_REG-1:0]  i_issue_dest,
   input  logic [NB_REG-1:0]  i_rs,
   input  logic [NB_REG-1:0]  i_rt,
   input  logic               i_flush,
   output logic [NB_DATA-1:0] o_data_input,
   output logic [NB_REG-1:0]  o_address_data,
   output logic               o_write,
   output logic               o_busy_rs,
   output logic               o_busy_rt,
   output logic               o_sb_error
);

   localparam int NREG = 1 << NB_REG;

   logic                  retire;
   logic                  issue;
   logic [NB_DATA-1:0]    sel_data;
   logic [NREG-1:0][1:0]  cnt;
   logic [NREG-1:0][1:0]  cnt_nxt;
   logic                  err_set;

   assign retire = i_valid & i_reg_write & (i_dest != '0);
   assign issue  = i_issue_valid & i_issue_reg_write
                 & (i_issue_dest != '0);

   wb_load_align #(
      .NB_DATA (NB_DATA),
      .NB_LOAD (NB_LOAD)
   ) u_align (
      .i_mem_to_reg  (i_mem_to_reg),
      .i_load_type   (i_load_type),
      .i_byte_offset (i_byte_offset),
      .i_alu_result  (i_alu_result),
      .i_mem_data    (i_mem_data),
      .o_data        (sel_data)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_write        <= 1'b0;
         o_data_input   <= '0;
         o_address_data <= '0;
      end else begin
         o_write <= retire;
         if (retire) begin
            o_data_input   <= sel_data;
            o_address_data <= i_dest;
         end
      end
   end

   // Matching issue and retire on one register cancel out.
   always_comb begin
      cnt_nxt = cnt;
      err_set = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         logic inc;
         logic dec;
         inc = issue  && (i_issue_dest == NB_REG'(r));
         dec = retire && (i_dest == NB_REG'(r));
         if (inc && !dec) begin
            if (cnt[r] == 2'd3) err_set = 1'b1;
            else                cnt_nxt[r] = cnt[r] + 2'd1;
         end else if (dec && !inc) begin
            if (cnt[r] == 2'd0) err_set = 1'b1;
            else                cnt_nxt[r] = cnt[r] - 2'd1;
         end
      end
      if (i_flush) begin
         cnt_nxt = '0;
         err_set = 1'b0;
      end
      cnt_nxt[0] = 2'd0;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt        <= '0;
         o_sb_error <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         o_sb_error <= o_sb_error | err_set;
      end
   end

   assign o_busy_rs = (i_rs != '0) && (cnt[i_rs] != 2'd0);
   assign o_busy_rt = (i_rt != '0) && (cnt[i_rt] != 2'd0);

endmodule

// File: tb/tb_wb_writeback.sv
// Self-checking bench for wb_writeback: load-alignment vector table,
// scoreboard corner sequences and a randomized run against a reference model.
module tb_wb_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, reg_write, mem_to_reg;
   logic [2:0]  load_type;
   logic [1:0]  byte_offset;
   logic [31:0] alu_result, mem_data;
   logic [4:0]  dest;
   logic        issue_valid, issue_reg_write;
   logic [4:0]  issue_dest, rs, rt;
   logic        flush;
   logic [31:0] data_input;
   logic [4:0]  address_data;
   logic        write, busy_rs, busy_rt, sb_error;

   int n_pass = 0;
   int n_tot  = 0;

   // reference model state
   int          pend [32];
   bit          m_err;
   bit          m_w;
   logic [31:0] m_d;
   logic [4:0]  m_a;

   always #5 clk = ~clk;

   wb_writeback dut (
      .i_clk             (clk),
      .i_reset           (rst),
      .i_valid           (valid),
      .i_reg_write       (reg_write),
      .i_mem_to_reg      (mem_to_reg),
      .i_load_type       (load_type),
      .i_byte_offset     (byte_offset),
      .i_alu_result      (alu_result),
      .i_mem_data        (mem_data),
      .i_dest            (dest),
      .i_issue_valid     (issue_valid),
      .i_issue_reg_write (issue_reg_write),
      .i_issue_dest      (issue_dest),
      .i_rs              (rs),
      .i_rt              (rt),
      .i_flush           (flush),
      .o_data_input      (data_input),
      .o_address_data    (address_data),
      .o_write           (write),
      .o_busy_rs         (busy_rs),
      .o_busy_rt         (busy_rt),
      .o_sb_error        (sb_error)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_data(bit m2r, logic [2:0] lt,
         logic [1:0] off, logic [31:0] alu, logic [31:0] mem);
      int unsigned bv, hv;
      bv = (mem >> (8 * off)) & 32'hFF;
      hv = (mem >> (16 * off[1])) & 32'hFFFF;
      if (!m2r) return alu;
      case (lt)
         3'd1:    return (bv >= 128) ? bv - 256 : bv;
         3'd2:    return bv;
         3'd3:    return (hv >= 32768) ? hv - 65536 : hv;
         3'd4:    return hv;
         default: return mem;
      endcase
   endfunction

   task automatic idle();
      valid = 0; reg_write = 0; mem_to_reg = 0; load_type = 0;
      byte_offset = 0; alu_result = 0; mem_data = 0; dest = 0;
      issue_valid = 0; issue_reg_write = 0; issue_dest = 0;
      rs = 0; rt = 0; flush = 0;
   endtask

   task automatic model_reset();
      foreach (pend[i]) pend[i] = 0;
      m_err = 0; m_w = 0; m_d = 0; m_a = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1;
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   // Sampled just after the edge; inputs are still the pre-edge values.
   task automatic model_edge();
      bit ret, iss;
      ret = valid && reg_write && dest != 0;
      iss = issue_valid && issue_reg_write && issue_dest != 0;
      m_w = ret;
      if (ret) begin
         m_a = dest;
         m_d = ref_data(mem_to_reg, load_type, byte_offset,
                        alu_result, mem_data);
      end
      if (flush) begin
         foreach (pend[i]) pend[i] = 0;
      end else if (!(iss && ret && issue_dest == dest)) begin
         if (iss) begin
            if (pend[issue_dest] == 3) m_err = 1;
            else pend[issue_dest]++;
         end
         if (ret) begin
            if (pend[dest] == 0) m_err = 1;
            else pend[dest]--;
         end
      end
   endtask

   task automatic issue_to(logic [4:0] d);
      @(negedge clk);
      idle();
      issue_valid = 1; issue_reg_write = 1; issue_dest = d;
      @(posedge clk);
   endtask

   task automatic retire_to(logic [4:0] d);
      @(negedge clk);
      idle();
      valid = 1; reg_write = 1; dest = d;
      alu_result = 32'h0000_1000 + 32'(d);
      @(posedge clk);
   endtask

   typedef struct {
      bit          m2r;
      logic [2:0]  lt;
      logic [1:0]  off;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [13];

   initial begin
      rst = 1;
      idle();
      model_reset();
      #2;
      chk("reset_write", 32'(write), 0);
      chk("reset_addr", 32'(address_data), 0);
      chk("reset_data", data_input, 0);
      chk("reset_err", 32'(sb_error), 0);
      @(negedge clk);
      rst = 0;

      vt[0]  = '{1, 3'd1, 2'd2, 32'h0, 32'h0080_FF11, 32'hFFFF_FF80};
      vt[1]  = '{1, 3'd2, 2'd2, 32'h0, 32'h0080_FF11, 32'h0000_0080};
      vt[2]  = '{1, 3'd1, 2'd1, 32'h0, 32'h0080_FF11, 32'hFFFF_FFFF};
      vt[3]  = '{1, 3'd2, 2'd0, 32'h0, 32'h0080_FF11, 32'h0000_0011};
      vt[4]  = '{1, 3'd4, 2'd2, 32'h0, 32'h8001_7FFF, 32'h0000_8001};
      vt[5]  = '{1, 3'd3, 2'd2, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001};
      vt[6]  = '{1, 3'd3, 2'd0, 32'h0, 32'h8001_7FFF, 32'h0000_7FFF};
      vt[7]  = '{1, 3'd3, 2'd1, 32'h0, 32'h8001_7FFF, 32'h0000_7FFF};
      vt[8]  = '{1, 3'd0, 2'd1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vt[9]  = '{1, 3'd5, 2'd0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vt[10] = '{1, 3'd7, 2'd3, 32'h0, 32'h0102_0304, 32'h0102_0304};
      vt[11] = '{0, 3'd1, 2'd2, 32'h1234_5678, 32'h0080_FF11,
                 32'h1234_5678};
      vt[12] = '{1, 3'd1, 2'd3, 32'h0, 32'h7F00_0000, 32'h0000_007F};

      // Issue to the same register each cycle so counters never move.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         idle();
         valid = 1; reg_write = 1; dest = 5'(i + 1);
         mem_to_reg = vt[i].m2r; load_type = vt[i].lt;
         byte_offset = vt[i].off; alu_result = vt[i].alu;
         mem_data = vt[i].mem;
         issue_valid = 1; issue_reg_write = 1; issue_dest = 5'(i + 1);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_write", i), 32'(write), 1);
         chk($sformatf("vec%0d_addr", i), 32'(address_data), i + 1);
         chk($sformatf("vec%0d_data", i), data_input, vt[i].exp);
      end
      chk("vec_no_err", 32'(sb_error), 0);

      // write to r0 is dropped, previous write-port values hold
      @(negedge clk);
      idle();
      valid = 1; reg_write = 1; dest = 0; alu_result = 32'h1234_5678;
      @(posedge clk); #1;
      chk("r0_write", 32'(write), 0);
      chk("r0_addr_hold", 32'(address_data), 13);
      chk("r0_data_hold", data_input, 32'h0000_007F);
      chk("r0_err", 32'(sb_error), 0);

      // valid without reg_write
      @(negedge clk);
      idle();
      valid = 1; dest = 4;
      @(posedge clk); #1;
      chk("nowr_write", 32'(write), 0);

      // two pending writes to r7
      issue_to(7);
      issue_to(7);
      retire_to(7);
      @(negedge clk);
      idle(); rs = 7; rt = 8;
      #1;
      chk("r7_busy_after1", 32'(busy_rs), 1);
      chk("r8_not_busy", 32'(busy_rt), 0);
      retire_to(7);
      @(negedge clk);
      idle(); rs = 7; rt = 7;
      #1;
      chk("r7_busy_after2", 32'(busy_rs), 0);
      chk("r7_busy_rt", 32'(busy_rt), 0);
      chk("r7_no_err", 32'(sb_error), 0);

      // overflow on r3 then flush
      for (int k = 0; k < 3; k++) issue_to(3);
      @(negedge clk);
      idle(); rt = 3;
      #1;
      chk("r3_busy_at3", 32'(busy_rt), 1);
      chk("r3_no_err_at3", 32'(sb_error), 0);
      issue_to(3);
      @(negedge clk);
      idle(); rt = 3;
      #1;
      chk("r3_overflow_err", 32'(sb_error), 1);
      // flush with a retire: counters clear, write still happens
      @(negedge clk);
      idle();
      flush = 1; valid = 1; reg_write = 1; dest = 3;
      alu_result = 32'hA5A5_0003;
      @(posedge clk); #1;
      chk("flush_write", 32'(write), 1);
      chk("flush_data", data_input, 32'hA5A5_0003);
      @(negedge clk);
      idle(); rt = 3; rs = 3;
      #1;
      chk("flush_busy", 32'(busy_rt), 0);
      chk("flush_err_sticky", 32'(sb_error), 1);
      @(posedge clk); #1;
      chk("err_still_sticky", 32'(sb_error), 1);

      // underflow on an idle register
      do_reset();
      chk("reset_err_clear", 32'(sb_error), 0);
      retire_to(9);
      #1;
      chk("underflow_err", 32'(sb_error), 1);

      // reset asserted between edges right after a retire
      do_reset();
      @(negedge clk);
      idle();
      valid = 1; reg_write = 1; dest = 5; mem_to_reg = 1;
      load_type = 1; byte_offset = 2; mem_data = 32'h0080_FF11;
      issue_valid = 1; issue_reg_write = 1; issue_dest = 6;
      @(posedge clk); #1;
      chk("pre_rst_write", 32'(write), 1);
      chk("pre_rst_data", data_input, 32'hFFFF_FF80);
      rs = 6;
      #1;
      chk("pre_rst_busy", 32'(busy_rs), 1);
      rst = 1;
      #1;
      chk("async_rst_write", 32'(write), 0);
      chk("async_rst_addr", 32'(address_data), 0);
      chk("async_rst_data", data_input, 0);
      chk("async_rst_busy", 32'(busy_rs), 0);
      @(negedge clk);
      rst = 0;
      idle();
      model_reset();

      // randomized run
      for (int c = 0; c < 3000; c++) begin
         if (c % 300 == 299) begin
            do_reset();
            continue;
         end
         @(negedge clk);
         idle();
         if ($urandom_range(49) == 0) begin
            flush = 1;
         end else begin
            valid = $urandom_range(1);
            reg_write = $urandom_range(3) != 0;
            dest = 5'($urandom_range(7));
            issue_valid = $urandom_range(1);
            issue_reg_write = $urandom_range(3) != 0;
            issue_dest = 5'($urandom_range(7));
         end
         mem_to_reg = $urandom_range(1);
         load_type = 3'($urandom_range(7));
         byte_offset = 2'($urandom_range(3));
         alu_result = $urandom;
         mem_data = $urandom;
         rs = 5'($urandom_range(8));
         rt = 5'($urandom_range(8));
         @(posedge clk); #1;
         model_edge();
         chk("rnd_write", 32'(write), 32'(m_w));
         chk("rnd_addr", 32'(address_data), 32'(m_a));
         chk("rnd_data", data_input, m_d);
         chk("rnd_busy_rs", 32'(busy_rs),
             32'(rs != 0 && pend[rs] != 0));
         chk("rnd_busy_rt", 32'(busy_rt),
             32'(rt != 0 && pend[rt] != 0));
         chk("rnd_err", 32'(sb_error), 32'(m_err));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
